dreg_banked: RTL and testbench
==============================

Name: dreg_banked

Overview:
- Parametrised successor to the core data register file: DEPTH entries of WIDTH bits, NRD asynchronous read ports, one write port.
- Entries split into a low (active) bank [0, DEPTH/2) and a high (shadow) bank [DEPTH/2, DEPTH).
- Write mirroring of low-bank writes into the shadow bank is runtime-selectable.
- A sequential bank-copy engine performs save (low→high) and restore (high→low) for context switching.

Parameters:
- WIDTH, 32, entry width in bits (matches `BITNESS).
- DEPTH, 32, entry count; power of two, >= 4. HALF = DEPTH/2; AW = $clog2(DEPTH) (localparams).
- NRD, 2, number of read ports, >= 1.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset, sampled on rising clk.
- ra  in  NRD*AW  read addresses; port p uses ra[p*AW +: AW].
- rval  out  NRD*WIDTH  read data; port p on rval[p*WIDTH +: WIDTH].
- w  in  1  write request.
- wa  in  AW  write address.
- wval  in  WIDTH  write data.
- w_ready  out  1  write port accepts; a write takes effect only when w && w_ready.
- mir  in  1  mirror enable, sampled with each accepted write.
- cp_req  in  1  start bank copy (single-cycle pulse or level; sampled in IDLE only).
- cp_dir  in  1  0 = save low→high, 1 = restore high→low; sampled with cp_req.
- cp_busy  out  1  copy engine active (COPY or DONE).
- cp_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst==0 at edge): all entries = 0; state IDLE; idx = 0; cp_busy = 0; cp_done = 0; w_ready = 1. Reset aborts a copy in progress with no partial result, since every entry is cleared. Reset has priority over all other inputs.
- Read: rval[p] = entry[ra[p]], combinational. A write is visible from the cycle after its acceptance; there is no same-cycle bypass (see Optional Feature).
- Write, accepted (w && w_ready): entry[wa] <= wval.
  - If mir==1 and wa < HALF, also entry[wa+HALF] <= wval in the same edge.
  - If wa >= HALF, only that entry is written, regardless of mir.
- w_ready = 1 in IDLE only, 0 in COPY and DONE. Writes presented while w_ready==0 are dropped; the requester holds w until w_ready.
- FSM states: IDLE, COPY, DONE.
  - IDLE: if cp_req, latch cp_dir, idx <= 0, go to COPY. A write accepted in the same cycle lands first, so the copy sees it.
  - COPY: each cycle, dst[idx] <= src[idx], where src/dst are low/high for save and high/low for restore (dst index = idx+HALF for save, idx for restore). idx increments each cycle; after idx == HALF-1 is copied, go to DONE.
  - DONE: cp_done = 1 for exactly this cycle; go to IDLE.
- Timing: cp_req sampled at edge k → COPY for HALF cycles → DONE for 1 cycle → IDLE. cp_busy is high for HALF+1 cycles. The next write is accepted HALF+2 edges after k.
- cp_req outside IDLE is ignored and not queued. cp_dir changes mid-copy have no effect.
- Reads stay live during a copy and return the pre-edge value of each entry being copied.
- The idx counter is AW-1 bits wide and does not wrap; exit from COPY is decided on idx == HALF-1.

Optional Feature:
- Macro: DREG_WR_BYPASS_EN.
- Defined: for each read port, if a write is accepted this cycle and ra[p]==wa, or (mir && wa<HALF && ra[p]==wa+HALF), then rval[p] = wval combinationally. Copy-engine writes are not bypassed.
- Undefined: reads return stored contents only; no comparators are instantiated.

Test Plan (WIDTH=32, DEPTH=32, NRD=2):
- Reset then read: rst=0 for 1 edge, then ra0=5, ra1=31 → rval both 0, w_ready=1, cp_busy=0, cp_done=0.
- Mirror: write wa=3, wval=32'hDEAD_BEEF, mir=1 → next cycle entry 3 and entry 19 read 32'hDEAD_BEEF. Then wa=3, wval=1, mir=0 → entry 3 = 1, entry 19 stays 32'hDEAD_BEEF. Write wa=20, wval=7, mir=1 → only entry 20 = 7, entry 4 unchanged.
- Save/restore: fill low entries i=0..15 with i+100. cp_req=1, cp_dir=0 → cp_busy high 17 cycles, cp_done pulses on the 17th, entries 16..31 = i+100. Overwrite low bank with 0, cp_req with cp_dir=1 → low entries restored to i+100.
- Write stall: during COPY, hold w=1, wa=2, wval=9 → w_ready=0 and no update until IDLE. Write is accepted on the first IDLE cycle; entry 2 = 9 afterwards. A second cp_req asserted mid-copy produces no extra cp_done.
- Reset mid-copy: assert rst=0 at the 5th COPY cycle → next cycle all entries 0, cp_busy=0, w_ready=1, no cp_done pulse.
- DREG_WR_BYPASS_EN defined: write wa=6, wval=32'h1234, mir=1 with ra0=6, ra1=22 in the same cycle → both rval = 32'h1234 that cycle. Undefined: both read the old value that cycle.

Source files
------------

// File: rtl/dreg_banked.sv
// dreg_banked: DEPTH x WIDTH register file split into an active low bank and a shadow high bank,
// with optional write mirroring and a save/restore bank-copy engine. Define DREG_WR_BYPASS_EN for write-to-read bypass.
module dreg_banked #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NRD   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NRD*$clog2(DEPTH)-1:0]      ra,
    output logic [NRD*WIDTH-1:0]              rval,
    input  logic                              w,
    input  logic [$clog2(DEPTH)-1:0]          wa,
    input  logic [WIDTH-1:0]                  wval,
    output logic                              w_ready,
    input  logic                              mir,
    input  logic                              cp_req,
    input  logic                              cp_dir,
    output logic                              cp_busy,
    output logic                              cp_done
);
    // state  | meaning
    // S_IDLE | write port open, waiting for cp_req
    // S_COPY | one entry per cycle moved between banks, writes stalled
    // S_DONE | copy finished, cp_done high for this cycle only

    localparam int AW   = $clog2(DEPTH);
    localparam int HALF = DEPTH / 2;
    localparam logic [AW-2:0] IDX_LAST = (AW-1)'(HALF - 1);

    typedef enum logic [1:0] {S_IDLE, S_COPY, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [AW-2:0]     r_idx;
    logic              r_dir;

    logic              w_wr_acc;
    logic              w_mir_hit;
    logic [AW-1:0]     w_mir_addr;
    logic [AW-1:0]     w_cp_src;
    logic [AW-1:0]     w_cp_dst;

    assign w_wr_acc   = w && w_ready;
    // Bank select is the address MSB because HALF is a power of two.
    assign w_mir_hit  = mir && !wa[AW-1];
    assign w_mir_addr = {1'b1, wa[AW-2:0]};
    assign w_cp_src   = {r_dir, r_idx};
    assign w_cp_dst   = {!r_dir, r_idx};

    assign w_ready = (r_state == S_IDLE);
    assign cp_busy = (r_state != S_IDLE);
    assign cp_done = (r_state == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (cp_req) w_state_nxt = S_COPY;
            S_COPY:  if (r_idx == IDX_LAST) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_dir   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_acc) begin
                r_mem[wa] <= wval;
                if (w_mir_hit) r_mem[w_mir_addr] <= wval;
            end
            if (r_state == S_COPY) r_mem[w_cp_dst] <= r_mem[w_cp_src];
            if (r_state == S_IDLE && cp_req) begin
                r_dir <= cp_dir;
                r_idx <= '0;
            end else if (r_state == S_COPY && r_idx != IDX_LAST) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] w_ra;
        assign w_ra = ra[p*AW +: AW];
`ifdef DREG_WR_BYPASS_EN
        logic w_byp;
        assign w_byp = w_wr_acc && ((w_ra == wa) || (w_mir_hit && (w_ra == w_mir_addr)));
        assign rval[p*WIDTH +: WIDTH] = w_byp ? wval : r_mem[w_ra];
`else
        assign rval[p*WIDTH +: WIDTH] = r_mem[w_ra];
`endif
    end

endmodule

// File: tb/tb_dreg_banked.sv
// tb_dreg_banked: scoreboard bench for dreg_banked (mirroring, save/restore, write stall, reset abort, bypass).
module tb_dreg_banked;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
    localparam int HALF  = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*WIDTH-1:0] rval;
    logic                 w;
    logic [AW-1:0]        wa;
    logic [WIDTH-1:0]     wval;
    logic                 w_ready;
    logic                 mir;
    logic                 cp_req;
    logic                 cp_dir;
    logic                 cp_busy;
    logic                 cp_done;

    dreg_banked #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .ra(ra), .rval(rval), .w(w), .wa(wa), .wval(wval),
        .w_ready(w_ready), .mir(mir), .cp_req(cp_req), .cp_dir(cp_dir),
        .cp_busy(cp_busy), .cp_done(cp_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        int               port;
        logic [WIDTH-1:0] exp;
    } rd_t;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] mdl [DEPTH];
    rd_t              sb [$];

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_push(input int port, input int addr, input string tag, input logic [WIDTH-1:0] exp);
        rd_t e;
        ra[port*AW +: AW] = AW'(addr);
        e.tag  = tag;
        e.port = port;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic rd(input int port, input int addr, input string tag);
        rd_push(port, addr, tag, mdl[addr]);
    endtask

    task automatic drain();
        rd_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, rval[e.port*WIDTH +: WIDTH], e.exp);
        end
    endtask

    task automatic wr(input int addr, input logic [WIDTH-1:0] data, input logic m);
        w    = 1'b1;
        wa   = AW'(addr);
        wval = data;
        mir  = m;
        chk("wr_ready", {31'b0, w_ready}, 32'd1);
        tick();
        w = 1'b0;
        mdl[addr] = data;
        if (m && addr < HALF) mdl[addr + HALF] = data;
    endtask

    task automatic run_copy(input logic dir, output int nb, output int da, output int nd);
        cp_req = 1'b1;
        cp_dir = dir;
        tick();
        cp_req = 1'b0;
        nb = 0; da = 0; nd = 0;
        while (cp_busy && nb < 40) begin
            nb++;
            if (cp_done) begin
                nd++;
                da = nb;
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb, da, nd, nrdy;
        logic [WIDTH-1:0] exp;

        rst = 1'b0; ra = '0; w = 1'b0; wa = '0; wval = '0; mir = 1'b0; cp_req = 1'b0; cp_dir = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        tick();
        rst = 1'b1;
        rd(0, 5, "rst_rd5");
        rd(1, 31, "rst_rd31");
        drain();
        chk("rst_ready", {31'b0, w_ready}, 32'd1);
        chk("rst_busy", {31'b0, cp_busy}, 32'd0);
        chk("rst_done", {31'b0, cp_done}, 32'd0);
        tick();

        // Write mirroring
        wr(3, 32'hDEAD_BEEF, 1'b1);
        rd(0, 3, "mir_e3"); rd(1, 19, "mir_e19"); drain(); tick();
        wr(3, 32'd1, 1'b0);
        rd(0, 3, "nomir_e3"); rd(1, 19, "nomir_e19"); drain(); tick();
        wr(20, 32'd7, 1'b1);
        rd(0, 20, "hi_e20"); rd(1, 4, "hi_e4"); drain(); tick();

        // Same-cycle read of an entry being written
        w = 1'b1; wa = 5'd6; wval = 32'h1234; mir = 1'b1;
`ifdef DREG_WR_BYPASS_EN
        exp = 32'h1234;
        rd_push(0, 6, "byp_p0", exp);
        rd_push(1, 22, "byp_p1", exp);
`else
        rd(0, 6, "byp_p0");
        rd(1, 22, "byp_p1");
`endif
        drain();
        tick();
        w = 1'b0;
        mdl[6] = 32'h1234; mdl[22] = 32'h1234;
        rd(0, 6, "byp_after_p0"); rd(1, 22, "byp_after_p1"); drain(); tick();

        // Save low -> high
        for (int i = 0; i < HALF; i++) wr(i, WIDTH'(i + 100), 1'b0);
        run_copy(1'b0, nb, da, nd);
        chk("save_busy_cycles", nb, 32'd17);
        chk("save_done_at", da, 32'd17);
        chk("save_done_count", nd, 32'd1);
        for (int i = 0; i < HALF; i++) mdl[i + HALF] = mdl[i];
        for (int i = 0; i < HALF; i++) begin
            rd(0, i + HALF, "save_hi");
            rd(1, i, "save_lo");
            drain(); tick();
        end

        // Clear low bank, then restore high -> low
        for (int i = 0; i < HALF; i++) wr(i, '0, 1'b0);
        rd(0, 0, "clr_e0"); rd(1, 15, "clr_e15"); drain(); tick();
        run_copy(1'b1, nb, da, nd);
        chk("rest_busy_cycles", nb, 32'd17);
        chk("rest_done_count", nd, 32'd1);
        for (int i = 0; i < HALF; i++) mdl[i] = mdl[i + HALF];
        for (int i = 0; i < HALF; i++) begin
            rd(0, i, "rest_lo");
            drain(); tick();
        end

        // Write stall during a save, with a stray cp_req and cp_dir flip mid-copy
        wr(5, 32'd55, 1'b0);
        cp_req = 1'b1; cp_dir = 1'b0;
        tick();
        cp_req = 1'b0;
        w = 1'b1; wa = 5'd2; wval = 32'd9; mir = 1'b0;
        nb = 0; nd = 0; nrdy = 0;
        while (cp_busy && nb < 40) begin
            nb++;
            if (cp_done) nd++;
            if (w_ready) nrdy++;
            cp_req = (nb == 3);
            cp_dir = (nb >= 3);
            if (nb == 8) begin
                rd(0, 2, "stall_e2");
                drain();
            end
            tick();
        end
        cp_req = 1'b0;
        chk("stall_busy_cycles", nb, 32'd17);
        chk("stall_done_count", nd, 32'd1);
        chk("stall_ready_seen", nrdy, 32'd0);
        chk("stall_ready_idle", {31'b0, w_ready}, 32'd1);
        tick();
        w = 1'b0;
        for (int i = 0; i < HALF; i++) mdl[i + HALF] = mdl[i];
        mdl[2] = 32'd9;
        chk("stall_no_recopy", {31'b0, cp_busy}, 32'd0);
        rd(0, 2, "stall_e2_after"); rd(1, 18, "stall_e18"); drain(); tick();
        rd(0, 5, "dirflip_e5"); rd(1, 21, "dirflip_e21"); drain(); tick();

        // Reset in the 5th COPY cycle
        cp_req = 1'b1; cp_dir = 1'b0;
        tick();
        cp_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_busy_pre", {31'b0, cp_busy}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_busy", {31'b0, cp_busy}, 32'd0);
        chk("mid_rst_ready", {31'b0, w_ready}, 32'd1);
        chk("mid_rst_done", {31'b0, cp_done}, 32'd0);
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (cp_done) nd++;
            tick();
        end
        chk("mid_rst_no_done", nd, 32'd0);
        for (int i = 0; i < HALF; i++) begin
            rd(0, i, "mid_rst_lo");
            rd(1, i + HALF, "mid_rst_hi");
            drain(); tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
